// File: rtl/ft2232h_fifo_tx.sv
// FT2232H synchronous 245-FIFO transmit engine: a 16-entry show-ahead byte FIFO
// drained onto ADBUS with WR#/TXE# flow control, all on the 60 MHz CLKOUT.
module ft2232h_fifo_tx #(
    parameter int ADDR_W = 4
) (
    input  logic              clkout_i,
    input  logic              rst_n_i,
    input  logic [7:0]        din_i,
    input  logic              push_i,
    input  logic              clear_i,
    output logic              full_o,
    output logic [ADDR_W:0]   level_o,
    output logic              overflow_o,
    output logic [31:0]       tx_count_o,
    output logic [7:0]        data_o,
    output logic              wr_n_o,
    input  logic              txe_n_i,
    output logic              fsm_state_o
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int LW    = ADDR_W + 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic              full_q, full_d;
    logic              overflow_q, overflow_d;
    logic [31:0]       tx_count_q, tx_count_d;
    logic              push_ok;
    logic              pop;

    // Handshake: a byte moves to the FT2232H only on an edge where WR# (our
    // registered wr_n_o) and TXE# (its ready) are both low; otherwise the head holds.
    assign pop     = (state_q == ST_WRITE) && !txe_n_i && (level_q != '0) && !clear_i;
    assign push_ok = push_i && !full_q && !clear_i;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        tx_count_d = tx_count_q;
        if (clear_i) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            level_d    = '0;
            overflow_d = 1'b0;
            tx_count_d = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop) begin
                rd_ptr_d   = rd_ptr_q + 1'b1;
                tx_count_d = tx_count_q + 32'd1;
            end
            if (push_i && full_q) overflow_d = 1'b1;
            level_d = level_q + LW'(push_ok) - LW'(pop);
        end
        full_d = (level_d == LW'(DEPTH));
    end

    always_ff @(posedge clkout_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
            tx_count_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
            tx_count_q <= tx_count_d;
        end
    end

    // Storage needs no reset: pointers and level decide what is valid.
    always_ff @(posedge clkout_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= din_i;
    end

    // FSM state register
    always_ff @(posedge clkout_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // FSM next state: same rule from both states, so a TXE# stall drops to IDLE
    always_comb begin
        state_d = ST_IDLE;
        if (!clear_i && !txe_n_i && (level_d != '0)) state_d = ST_WRITE;
    end

    // FSM outputs
    always_comb begin
        wr_n_o      = (state_q != ST_WRITE);
        fsm_state_o = state_q;
    end

    assign data_o     = (level_q != '0) ? mem_q[rd_ptr_q] : 8'h00;
    assign full_o     = full_q;
    assign level_o    = level_q;
    assign overflow_o = overflow_q;
    assign tx_count_o = tx_count_q;

endmodule

// File: doc/ft2232h_fifo_tx.md
# ft2232h_fifo_tx

FPGA-side transmit engine for the FT2232H synchronous 245-FIFO interface. It buffers bytes pushed by on-chip logic in a small show-ahead FIFO and drains them to the FT2232H using wr_n/txe_n flow control, with no byte lost or duplicated across txe_n stalls. It sits between the acquisition datapath and the FT2232H pins and runs entirely on the FT2232H 60 MHz CLKOUT.

## Interface
- ADDR_W, 4, log2 of FIFO depth (depth = 2^ADDR_W = 16)
- clkout_i  in  1  FT2232H CLKOUT, sole clock, all logic on rising edge
- rst_n_i  in  1  asynchronous, active-low reset
- din_i  in  8  byte to enqueue
- push_i  in  1  enqueue din_i this cycle
- clear_i  in  1  synchronous flush
- full_o  out  1  level == 2^ADDR_W
- level_o  out  ADDR_W+1  bytes held
- overflow_o  out  1  sticky: push_i seen while full
- tx_count_o  out  32  bytes accepted by FT2232H, wraps modulo 2^32
- data_o  out  8  FT2232H ADBUS drive
- wr_n_o  out  1  FT2232H WR#, active low, registered
- txe_n_i  in  1  FT2232H TXE#, low = FT2232H can accept

## Operation
- Transfer: a byte is taken by the FT2232H on a rising edge where wr_n_o == 0 and txe_n_i == 0. Only such an edge is a pop: rd_ptr += 1, level -= 1, tx_count += 1.
- Push: accepted when push_i == 1 and full_o == 0 (current level, before any same-cycle pop). Push while full is dropped and sets overflow_o; the stored contents do not change.
- level_next = level + push_ok − pop; simultaneous push and pop leave level unchanged.
- data_o = mem[rd_ptr] when level != 0, else 8'h00. data_o is combinational from the head entry.
- Two-state FSM on wr_n_o:
  - IDLE (wr_n_o = 1)
  - WRITE (wr_n_o = 0)
  - next state is WRITE iff txe_n_i == 0 and level_next != 0; otherwise IDLE. This is evaluated every edge in both states.
- Stall: if txe_n_i is high on an edge while in WRITE, no pop occurs. The head byte stays on data_o and the FSM goes to IDLE. It returns to WRITE on the first edge where txe_n_i is low again.
- Pointers are ADDR_W bits and wrap naturally. level is ADDR_W+1 bits and distinguishes full from empty.
- clear_i takes priority over push and pop: rd_ptr, wr_ptr and level go to 0, wr_n_o = 1, overflow_o = 0, tx_count_o = 0. push_i in the same cycle is ignored.

## Timing
- Reset values: wr_n_o = 1, data_o = 8'h00, level_o = 0, full_o = 0, overflow_o = 0, tx_count_o = 0. Reset asserted mid-burst discards FIFO contents and releases wr_n_o immediately, asynchronously.
- Latency with txe_n_i low: a byte pushed into an empty FIFO at edge N gives wr_n_o = 0 with that byte on data_o after edge N. It transfers at edge N+1.
- Back-to-back: with txe_n_i held low and the FIFO non-empty, one byte transfers per clock and wr_n_o stays low.
- Last byte: the edge that pops the final byte (with no same-cycle push) drives wr_n_o high.
- txe_n_i rising to wr_n_o deassertion takes one edge. A byte presented during the txe_n_i-high edge is retained, not lost.
- full_o, level_o, overflow_o and tx_count_o are registered, and update on the edge of the event that changes them.

## Test plan
- Single byte: push 8'hA5 with txe_n_i low -> wr_n_o low for exactly 1 cycle, host captures A5, tx_count_o = 1, level_o = 0.
- Burst: push 0x00..0x0F, txe_n_i low -> 16 consecutive transfers, wr_n_o low for 16 cycles, host sees 00..0F in order.
- Stall: 10-byte burst with txe_n_i high for 3 cycles after the 4th transfer -> host sequence exactly 0..9, no gap or repeat, tx_count_o = 10.
- Full/overflow: txe_n_i high, push 17 bytes -> full_o = 1 after 16, overflow_o = 1, level_o = 16; then txe_n_i low -> 16 bytes drain, the 17th is absent.
- Simultaneous push/pop at level 1 under streaming -> level_o stays 1 and the order is preserved.
- Reset/clear mid-burst: assert rst_n_i low (then in a separate run, clear_i) after 5 of 12 bytes -> wr_n_o goes high, level_o = 0, tx_count_o = 0. A new push of 8'h3C then transfers correctly.
